// File: rtl/load_use_hazard_unit_pkg.sv
// pipeline_pkg: hazard FSM states and the stall/flush control bundle shared with the pipeline top
package pipeline_pkg;
    typedef enum logic [0:0] {RUN, LU_STALL} hz_state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic hold;
    } hz_ctrl_t;
    localparam hz_ctrl_t CTL_RESET  = 5'b00110;
    localparam hz_ctrl_t CTL_FREEZE = 5'b00001;
    localparam hz_ctrl_t CTL_FLUSH  = 5'b11110;
    localparam hz_ctrl_t CTL_STALL  = 5'b00010;
    localparam hz_ctrl_t CTL_RUN    = 5'b11000;
endpackage

// File: rtl/load_use_hazard_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit: detects load-use hazards against ID/EX, sequences multi-cycle stalls,
// and arbitrates them against memory-busy freezes and branch flushes
module load_use_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int LU_STALLS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] hazard_events
);
    localparam logic [2:0] LU_INIT = 3'(LU_STALLS - 1);
    hz_state_t  state, state_n;
    logic [2:0] cnt, cnt_n;
    hz_ctrl_t   ctl;
    logic       hazard, hz_inc;
    assign hazard = id_valid && ex_memread && ex_rd != REG_X0 &&
                    (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    always_comb begin
        ctl     = CTL_RUN;
        state_n = state;
        cnt_n   = cnt;
        hz_inc  = 1'b0;
        if (rst) begin
            ctl = CTL_RESET;
        end else if (mem_busy) begin
            ctl = CTL_FREEZE;
        end else if (flush) begin
            ctl     = CTL_FLUSH;
            state_n = RUN;
            cnt_n   = 3'd0;
        end else if (state == LU_STALL) begin
            ctl     = CTL_STALL;
            cnt_n   = cnt - 3'd1;
            state_n = cnt == 3'd1 ? RUN : LU_STALL;
        end else if (hazard) begin
            // single-cycle configurations resolve the whole stall without leaving RUN
            ctl     = CTL_STALL;
            hz_inc  = 1'b1;
            state_n = LU_STALLS > 1 ? LU_STALL : RUN;
            cnt_n   = LU_INIT;
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    assign pc_write_en    = ctl.pc_we;
    assign if_id_write_en = ctl.ifid_we;
    assign if_id_flush    = ctl.ifid_flush;
    assign id_ex_bubble   = ctl.idex_bubble;
    assign pipe_hold      = ctl.hold;
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!ctl.pc_we),
        .count (stall_cycles)
    );
    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz_inc),
        .count (hazard_events)
    );
endmodule

// File: tb/tb_load_use_hazard_unit.sv
// tb_load_use_hazard_unit: three configurations (LU_STALLS=1/3, CNT_W=32/4) driven in parallel
// and compared against a remaining-stall-cycles reference model
module tb_load_use_hazard_unit;
    localparam int LS[3] = '{1, 3, 3};
    localparam int WS[3] = '{32, 32, 4};

    logic clk = 1'b0;
    logic rst, id_valid, id_uses_rs2, ex_memread, flush, mem_busy;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [4:0] ctl0, ctl1, ctl2;
    logic [31:0] sc0, hz0, sc1, hz1;
    logic [3:0] sc2, hz2;

    int n_chk = 0, n_pass = 0;
    int rem[3];
    longint hzm[3], scm[3];

    always #5 clk = ~clk;

    load_use_hazard_unit #(.LU_STALLS(1), .CNT_W(32)) d0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .mem_busy(mem_busy), .pc_write_en(ctl0[4]), .if_id_write_en(ctl0[3]),
        .if_id_flush(ctl0[2]), .id_ex_bubble(ctl0[1]), .pipe_hold(ctl0[0]),
        .stall_cycles(sc0), .hazard_events(hz0));
    load_use_hazard_unit #(.LU_STALLS(3), .CNT_W(32)) d1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .mem_busy(mem_busy), .pc_write_en(ctl1[4]), .if_id_write_en(ctl1[3]),
        .if_id_flush(ctl1[2]), .id_ex_bubble(ctl1[1]), .pipe_hold(ctl1[0]),
        .stall_cycles(sc1), .hazard_events(hz1));
    load_use_hazard_unit #(.LU_STALLS(3), .CNT_W(4)) d2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_memread(ex_memread), .ex_rd(ex_rd), .flush(flush),
        .mem_busy(mem_busy), .pc_write_en(ctl2[4]), .if_id_write_en(ctl2[3]),
        .if_id_flush(ctl2[2]), .id_ex_bubble(ctl2[1]), .pipe_hold(ctl2[0]),
        .stall_cycles(sc2), .hazard_events(hz2));

    function automatic bit haz();
        return id_valid && ex_memread && ex_rd != 0 &&
               (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    endfunction

    // expected {pc_we, ifid_we, ifid_flush, bubble, hold} for configuration i this cycle
    function automatic logic [4:0] exp_ctl(int i);
        if (rst) return 5'b00110;
        if (mem_busy) return 5'b00001;
        if (flush) return 5'b11110;
        if (rem[i] > 0 || haz()) return 5'b00010;
        return 5'b11000;
    endfunction

    function automatic longint satv(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return v > mx ? mx : v;
    endfunction

    task automatic set_in(logic r, logic v, logic [4:0] rs1, logic [4:0] rs2, logic u2,
                          logic mr, logic [4:0] rd, logic fl, logic bz);
        rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_memread = mr; ex_rd = rd; flush = fl; mem_busy = bz;
        #2;
    endtask

    // advance the model by the current inputs, then clock the DUTs
    task automatic adv();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                rem[i] = 0; hzm[i] = 0; scm[i] = 0;
            end else if (mem_busy) begin
                scm[i]++;
            end else if (flush) begin
                rem[i] = 0;
            end else if (rem[i] > 0) begin
                rem[i]--; scm[i]++;
            end else if (haz()) begin
                hzm[i]++; scm[i]++; rem[i] = LS[i] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            adv();
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(1, 1, 5, 0, 0, 1, 5, 0, 0);
            n_chk++;
            if (ctl1 !== 5'b00110) $display("FAIL reset_outputs: got %b exp 00110", ctl1);
            else n_pass++;
            adv();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ctl0 !== 5'b11000) $display("FAIL post_reset_run: got %b exp 11000", ctl0);
        else n_pass++;
        n_chk++;
        if (sc1 !== 0 || hz1 !== 0 || sc2 !== 0) $display("FAIL post_reset_counters: got %0d/%0d/%0d exp 0", sc1, hz1, sc2);
        else n_pass++;
        adv();
    endtask

    task automatic test_lu_single();
        idle(1);
        set_in(0, 1, 5, 0, 0, 1, 5, 0, 0);
        n_chk++;
        if (ctl0 !== 5'b00010) $display("FAIL lu1_stall: got %b exp 00010", ctl0);
        else n_pass++;
        adv();
        set_in(0, 1, 5, 0, 0, 0, 5, 0, 0);
        n_chk++;
        if (ctl0 !== 5'b11000) $display("FAIL lu1_resume: got %b exp 11000", ctl0);
        else n_pass++;
        n_chk++;
        if (hz0 !== 1 || sc0 !== 1) $display("FAIL lu1_counters: got hz=%0d sc=%0d exp 1/1", hz0, sc0);
        else n_pass++;
        adv();
        idle(3);
    endtask

    task automatic test_rs2_multi();
        logic [5:0] pat;
        longint hz_before = hzm[1];
        pat = '0;
        for (int k = 0; k < 6; k++) begin
            set_in(0, 1, 3, 7, 1, k == 0, 7, 0, 0);
            pat = {pat[4:0], ~ctl1[4]};
            adv();
        end
        n_chk++;
        if (pat !== 6'b111000) $display("FAIL lu3_rs2_pattern: got %b exp 111000", pat);
        else n_pass++;
        n_chk++;
        if (hz1 !== 32'(hz_before + 1)) $display("FAIL lu3_rs2_events: got %0d exp %0d", hz1, hz_before + 1);
        else n_pass++;
        set_in(0, 1, 3, 7, 0, 1, 7, 0, 0);
        n_chk++;
        if (ctl1 !== 5'b11000) $display("FAIL rs2_unused: got %b exp 11000", ctl1);
        else n_pass++;
        set_in(0, 1, 0, 0, 1, 1, 0, 0, 0);
        n_chk++;
        if (ctl1 !== 5'b11000) $display("FAIL rd_x0: got %b exp 11000", ctl1);
        else n_pass++;
        set_in(0, 0, 9, 9, 1, 1, 9, 0, 0);
        n_chk++;
        if (ctl1 !== 5'b11000) $display("FAIL id_invalid: got %b exp 11000", ctl1);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_priority();
        longint hz_before = hzm[1];
        set_in(0, 1, 5, 0, 0, 1, 5, 1, 0);
        n_chk++;
        if (ctl1 !== 5'b11110) $display("FAIL flush_over_hazard: got %b exp 11110", ctl1);
        else n_pass++;
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (hz1 !== 32'(hz_before)) $display("FAIL flush_no_event: got %0d exp %0d", hz1, hz_before);
        else n_pass++;
        set_in(0, 1, 5, 0, 0, 1, 5, 0, 0);
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_chk++;
        if (ctl1 !== 5'b11110) $display("FAIL flush_mid_stall: got %b exp 11110", ctl1);
        else n_pass++;
        adv();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (ctl1 !== 5'b11000) $display("FAIL stall_abandoned: got %b exp 11000", ctl1);
        else n_pass++;
        adv();
    endtask

    task automatic test_busy();
        longint sc_before;
        idle(1);
        set_in(0, 1, 5, 0, 0, 1, 5, 0, 0);
        adv();
        sc_before = scm[1];
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, 5, 0, 0, 0, 5, 0, 1);
            n_chk++;
            if (ctl1 !== 5'b00001) $display("FAIL busy_freeze%0d: got %b exp 00001", k, ctl1);
            else n_pass++;
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 5, 0, 0, 0, 5, 0, 0);
            n_chk++;
            if (ctl1 !== (k < 2 ? 5'b00010 : 5'b11000)) $display("FAIL busy_resume%0d: got %b exp %b", k, ctl1, k < 2 ? 5'b00010 : 5'b11000);
            else n_pass++;
            adv();
        end
        n_chk++;
        if (sc1 !== 32'(sc_before + 6)) $display("FAIL busy_stall_count: got %0d exp %0d", sc1, sc_before + 6);
        else n_pass++;
    endtask

    task automatic test_saturate_and_reset();
        for (int k = 0; k < 20; k++) begin
            set_in(0, 1, 5, 0, 0, 1, 5, 0, 0);
            adv();
            idle(2);
        end
        n_chk++;
        if (hz2 !== 4'hF || sc2 !== 4'hF) $display("FAIL cnt4_saturate: got hz=%h sc=%h exp F/F", hz2, sc2);
        else n_pass++;
        n_chk++;
        if (hz0 !== 32'(hzm[0])) $display("FAIL cnt32_events: got %0d exp %0d", hz0, hzm[0]);
        else n_pass++;
        set_in(0, 1, 5, 0, 0, 1, 5, 0, 0);
        adv();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
            n_chk++;
            if (ctl1 !== 5'b11000 || ctl2 !== 5'b11000) $display("FAIL reset_mid_stall%0d: got %b/%b exp 11000", k, ctl1, ctl2);
            else n_pass++;
            adv();
        end
        n_chk++;
        if (hz2 !== 0 || sc2 !== 0) $display("FAIL reset_counters: got hz=%0d sc=%0d exp 0", hz2, sc2);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            set_in($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            n_chk++;
            if (ctl0 !== exp_ctl(0)) $display("FAIL rnd_ctl0 @%0d: got %b exp %b", k, ctl0, exp_ctl(0));
            else n_pass++;
            n_chk++;
            if (ctl1 !== exp_ctl(1)) $display("FAIL rnd_ctl1 @%0d: got %b exp %b", k, ctl1, exp_ctl(1));
            else n_pass++;
            n_chk++;
            if (ctl2 !== exp_ctl(2)) $display("FAIL rnd_ctl2 @%0d: got %b exp %b", k, ctl2, exp_ctl(2));
            else n_pass++;
            n_chk++;
            if (sc0 !== 32'(satv(scm[0], 32)) || hz0 !== 32'(satv(hzm[0], 32)))
                $display("FAIL rnd_cnt0 @%0d: got %0d/%0d exp %0d/%0d", k, sc0, hz0, scm[0], hzm[0]);
            else n_pass++;
            n_chk++;
            if (sc1 !== 32'(satv(scm[1], 32)) || hz1 !== 32'(satv(hzm[1], 32)))
                $display("FAIL rnd_cnt1 @%0d: got %0d/%0d exp %0d/%0d", k, sc1, hz1, scm[1], hzm[1]);
            else n_pass++;
            n_chk++;
            if (sc2 !== 4'(satv(scm[2], 4)) || hz2 !== 4'(satv(hzm[2], 4)))
                $display("FAIL rnd_cnt2 @%0d: got %0d/%0d exp %0d/%0d", k, sc2, hz2, satv(scm[2], 4), satv(hzm[2], 4));
            else n_pass++;
            adv();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; hzm[i] = 0; scm[i] = 0;
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_lu_single();
        test_rs2_multi();
        test_priority();
        test_busy();
        test_saturate_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
